uart_rx_fifo: RTL and testbench

Parametrised second-generation UART receiver with a built-in baud tick divider, 2-flop input synchroniser, majority-vote bit sampling, and configurable word length, parity and stop bits. Each received word is pushed, with per-word parity and framing error flags, into a show-ahead receive FIFO. An overrun is reported through a sticky flag. The block sits between the `rxd` pin and the host-side register interface and replaces the single-register receive path.

---
 rtl/uart_rx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a show-ahead FIFO with per-word error flags
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_overrun
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SC_A     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_B     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_C     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BITS_ALL = BW'(DATA_BITS);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);
  localparam logic          STOP_END = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q;
  logic [1:0]           sync_q;
  logic [SW-1:0]        sc_q, sc_d;
  logic [1:0]           smp_q, smp_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, stop_q, stop_d, armed_q, armed_d;
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 ovr_q;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic                 tick, rxs, vote, decide, wrap, exp_par, push, pop, push_ok;
  logic [EW-1:0]        head;

  assign tick    = div_q == DIV_LAST;
  assign rxs     = sync_q[1];
  assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign decide  = tick && sc_q == SC_C;
  assign wrap    = tick && sc_q == SC_LAST;
  assign exp_par = (PARITY == 2) ? ^shift_q : ~^shift_q;

  // armed_q blocks start detection until the line has been seen idle, so a break is not re-read as frames
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    smp_d   = smp_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stop_d  = stop_q;
    push    = 1'b0;
    armed_d = (state_q == S_IDLE) ? (armed_q | rxs) : 1'b0;
    if (tick) begin
      sc_d     = sc_q + 1'b1;
      smp_d[0] = (sc_q == SC_A) ? rxs : smp_q[0];
      smp_d[1] = (sc_q == SC_B) ? rxs : smp_q[1];
      case (state_q)
        S_IDLE: begin
          sc_d = '0;
          if (!rxs && armed_q) begin
            state_d = S_START;
            sc_d    = SW'(1);
            bcnt_d  = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            stop_d  = 1'b0;
          end
        end
        S_START: state_d = (decide && vote) ? S_IDLE : (wrap ? S_DATA : S_START);
        S_DATA: begin
          if (decide) begin
            shift_d = {vote, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
          end
          if (wrap && bcnt_q == BITS_ALL) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: begin
          perr_d  = decide ? (vote != exp_par) : perr_q;
          state_d = wrap ? S_STOP : S_PAR;
        end
        S_STOP: begin
          if (decide) begin
            ferr_d = ferr_q | ~vote;
            if (stop_q == STOP_END) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pop     = rd_en && cnt_q != '0;
  assign push_ok = push && (cnt_q != FULL || pop);

  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sync_q  <= 2'b11;
      sc_q    <= '0;
      smp_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stop_q  <= 1'b0;
      armed_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= tick ? '0 : div_q + 1'b1;
      sync_q  <= {sync_q[0], rxd};
      sc_q    <= sc_d;
      smp_q   <= smp_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      stop_q  <= stop_d;
      armed_q <= armed_d;
      wr_q    <= push_ok ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q   <= cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      ovr_q   <= (push && !push_ok) || (ovr_q && !clr_overrun);
    end

  always_ff @(posedge sysclk)
    if (push_ok) mem_q[wr_q] <= {ferr_d, perr_q, shift_q};

  assign head          = mem_q[rd_q];
  assign rd_valid      = cnt_q != '0;
  assign rd_data       = rd_valid ? head[DATA_BITS-1:0] : '0;
  assign rd_parity_err = rd_valid & head[DATA_BITS];
  assign rd_frame_err  = rd_valid & head[DATA_BITS+1];
  assign fifo_count    = cnt_q;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of an 8N1 receiver and an 8E1 receiver sharing clock and reset
module tb_uart_rx_fifo;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic rxd_n = 1'b1, rxd_e = 1'b1, rd_en_n = 1'b0, rd_en_e = 1'b0;
  logic [7:0] data_n, data_e;
  logic perr_n, perr_e, ferr_n, ferr_e, val_n, val_e, ovr_n, ovr_e;
  logic [2:0] cnt_n, cnt_e;
  int errors = 0, checks = 0;
  bit seen;

  always #5 clk = ~clk;

  uart_rx_fifo dn (
    .sysclk(clk), .rst(rst), .rxd(rxd_n), .rd_en(rd_en_n), .rd_data(data_n),
    .rd_parity_err(perr_n), .rd_frame_err(ferr_n), .rd_valid(val_n),
    .fifo_count(cnt_n), .overrun(ovr_n), .clr_overrun(clr)
  );

  uart_rx_fifo #(.PARITY(2)) de (
    .sysclk(clk), .rst(rst), .rxd(rxd_e), .rd_en(rd_en_e), .rd_data(data_e),
    .rd_parity_err(perr_e), .rd_frame_err(ferr_e), .rd_valid(val_e),
    .fifo_count(cnt_e), .overrun(ovr_e), .clr_overrun(clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8e(input logic [7:0] d, input logic p, input logic s);
    return {5'b0, s, p, d, 1'b0};
  endfunction

  // one bit = 32 cycles; optional 4-cycle (one tick) inversion inside bit gbit starting at cycle goff
  task automatic send(input bit which, input logic [15:0] bits, input int n, input int gbit, input int goff);
    logic v;
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 32; c++) begin
        v = bits[i];
        if (i == gbit && c >= goff && c < goff + 4) v = ~v;
        if (which) rxd_e = v; else rxd_n = v;
        @(negedge clk);
      end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop(input bit which);
    if (which) rd_en_e = 1'b1; else rd_en_n = 1'b1;
    @(negedge clk);
    rd_en_e = 1'b0;
    rd_en_n = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", val_n, 0);
    chk("rst_count", cnt_n, 0);
    chk("rst_data", data_n, 0);
    chk("rst_errs", {ferr_n, perr_n}, 0);
    chk("rst_overrun", ovr_n, 0);
    chk("rst_e_valid_count", {val_e, cnt_e}, 0);
    rst = 1'b0;
    idle(20);

    send(0, f8n1(8'hA5, 1'b1), 10, -1, 0);
    chk("a5_valid", val_n, 1);
    chk("a5_data", data_n, 8'hA5);
    chk("a5_errs", {ferr_n, perr_n}, 0);
    chk("a5_count", cnt_n, 1);
    pop(0);
    chk("a5_pop_valid", val_n, 0);
    chk("a5_pop_data", data_n, 0);

    send(1, f8e(8'h03, 1'b1, 1'b1), 11, -1, 0);
    chk("p03_data", data_e, 8'h03);
    chk("p03_perr", perr_e, 1);
    chk("p03_ferr", ferr_e, 0);
    pop(1);
    send(1, f8e(8'h07, 1'b1, 1'b1), 11, -1, 0);
    chk("p07_data", data_e, 8'h07);
    chk("p07_errs", {ferr_e, perr_e}, 0);
    pop(1);
    send(1, f8e(8'h55, 1'b0, 1'b0), 11, -1, 0);
    rxd_e = 1'b1;
    idle(64);
    chk("f55_data", data_e, 8'h55);
    chk("f55_ferr", ferr_e, 1);
    chk("f55_perr", perr_e, 0);
    chk("f55_count", cnt_e, 1);
    pop(1);
    chk("e_empty", val_e, 0);

    rxd_n = 1'b0;
    idle(8);
    rxd_n = 1'b1;
    idle(96);
    chk("glitch_valid", val_n, 0);
    chk("glitch_count", cnt_n, 0);

    send(0, f8n1(8'h0F, 1'b1), 10, 1, 14);
    chk("vote0f_a", data_n, 8'h0F);
    chk("vote0f_a_errs", {ferr_n, perr_n}, 0);
    pop(0);
    send(0, f8n1(8'h0F, 1'b1), 10, 5, 20);
    chk("vote0f_b", data_n, 8'h0F);
    pop(0);

    for (int i = 1; i <= 5; i++) send(0, f8n1(8'(8'h11 * i), 1'b1), 10, -1, 0);
    chk("ovr_count", cnt_n, 4);
    chk("ovr_flag", ovr_n, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_order", data_n, 8'h11 * i);
      pop(0);
    end
    chk("ovr_drained", cnt_n, 0);
    chk("ovr_sticky", ovr_n, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr", ovr_n, 0);

    send(0, f8n1(8'hF0, 1'b1), 5, -1, 0);
    rxd_n = 1'b1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(100);
    chk("midrst_valid", val_n, 0);
    chk("midrst_count", cnt_n, 0);
    send(0, f8n1(8'h3C, 1'b1), 10, -1, 0);
    chk("after_rst_data", data_n, 8'h3C);
    chk("after_rst_count", cnt_n, 1);
    pop(0);

    for (int i = 1; i <= 4; i++) send(0, f8n1(8'(i), 1'b1), 10, -1, 0);
    chk("full_count", cnt_n, 4);
    seen = 1'b0;
    fork
      send(0, f8n1(8'h05, 1'b1), 10, -1, 0);
      for (int c = 0; c < 400 && !seen; c++) begin
        @(negedge clk);
        if (dn.push) begin
          seen = 1'b1;
          rd_en_n = 1'b1;
          @(negedge clk);
          rd_en_n = 1'b0;
        end
      end
    join
    chk("push_pop_seen", seen, 1);
    chk("push_pop_count", cnt_n, 4);
    chk("push_pop_overrun", ovr_n, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("push_pop_order", data_n, i);
      pop(0);
    end
    chk("final_empty", val_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
